// File: rtl/gf2_poly_div_9bit_if.sv
// Handshake bundle for the GF(2)[x] divider: operand request channel and result channel.
interface gf2_poly_div_9bit_if #(
  parameter int unsigned N = 9
);
  localparam int unsigned W = 2 * N - 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [N-2:0] r;
  logic         div_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, div_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, div_zero
  );
endinterface

// File: rtl/gf2_poly_div_9bit.sv
// Sequential GF(2)[x] long divider: 17-bit dividend by 9-bit divisor, one dividend bit per clock.
// Returns quotient, remainder and a divide-by-zero flag over a valid/ready handshake.
module gf2_poly_div_9bit (
  input  logic                  clk,
  input  logic                  rst,
  gf2_poly_div_9bit_if.slave    bus
);
  localparam int unsigned N  = 9;
  localparam int unsigned W  = 2 * N - 1;
  localparam int unsigned KW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [W-1:0]    r_rem;
  logic [N-1:0]    r_div;
  logic [KW-1:0]   r_deg;
  logic [KW-1:0]   r_k;
  logic [W-1:0]    r_q;
  logic [N-2:0]    r_r;
  logic            r_dz;

  logic [KW-1:0]   w_deg;
  logic            w_b_nz;
  logic [KW-1:0]   w_shamt;
  logic            w_hit;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_q_nxt;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.q         = r_q;
  assign bus.r         = r_r;
  assign bus.div_zero  = r_dz;

  assign w_b_nz = |bus.b;

  // Degree of the divisor: index of the highest set bit.
  always_comb begin
    w_deg = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.b[i]) w_deg = KW'(i);
    end
  end

  // One long-division step at bit position k.
  always_comb begin
    w_shamt   = r_k - r_deg;
    w_hit     = (r_k >= r_deg) && r_rem[r_k];
    w_rem_nxt = r_rem;
    w_q_nxt   = r_q;
    if (w_hit) begin
      w_rem_nxt          = r_rem ^ (W'(r_div) << w_shamt);
      w_q_nxt[w_shamt]   = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (bus.in_valid) w_state_nxt = w_b_nz ? S_RUN : S_DONE;
      S_RUN:  if (r_k == '0) w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_div <= '0;
      r_deg <= '0;
      r_k   <= KW'(W - 1);
      r_q   <= '0;
      r_r   <= '0;
      r_dz  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (w_b_nz) begin
              r_rem <= bus.a;
              r_div <= bus.b;
              r_deg <= w_deg;
              r_q   <= '0;
              r_k   <= KW'(W - 1);
            end else begin
              r_dz  <= 1'b1;
              r_q   <= '0;
              r_r   <= '0;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          if (r_k == '0) begin
            r_r <= w_rem_nxt[N-2:0];
            r_k <= KW'(W - 1);
          end else begin
            r_k <= r_k - KW'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
